// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_search_pkg;

  // Controller states; S_WAIT is only reachable when the comparator has one cycle of latency.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Widest operand the one-hot mask helper can produce.
  localparam int MAX_BW = 64;

  // Width of the probe counter: it must hold the value BW itself.
  function automatic int iters_width(input int bw);
    return $clog2(bw + 1);
  endfunction

  // Width of the bit-index down-counter (at least one bit, even for BW=1).
  function automatic int index_width(input int bw);
    return (bw > 1) ? $clog2(bw) : 1;
  endfunction

  // One-hot mask with bit i set; callers truncate it to their operand width.
  function automatic logic [MAX_BW-1:0] bit_mask(input int unsigned i);
    return {{(MAX_BW-1){1'b0}}, 1'b1} << i;
  endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search controller: drives trial operands into an
// external magnitude comparator and converges MSB-first onto its hidden threshold.
module sar_search
  import sar_search_pkg::*;
#(
  parameter  int BW         = 8,
  parameter  int CMP_LAT    = 0,
  parameter  int EARLY_EXIT = 1,
  localparam int IW         = iters_width(BW)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_abort,
  output logic          o_probe_valid,
  output logic [BW-1:0] o_probe,
  input  logic          i_cmp_lte,
  input  logic          i_cmp_eq,
  output logic          o_resp_valid,
  input  logic          i_resp_ready,
  output logic [BW-1:0] o_result,
  output logic [IW-1:0] o_iters
);

  localparam int            XW       = index_width(BW);
  localparam logic [XW-1:0] LAST_IDX = XW'(BW - 1);

  // Reject configurations the datapath cannot support.
  if (CMP_LAT != 0 && CMP_LAT != 1) begin : g_bad_cmp_lat
    $error("sar_search: CMP_LAT must be 0 or 1");
  end
  if (BW < 1 || BW > MAX_BW) begin : g_bad_bw
    $error("sar_search: BW out of supported range");
  end

  state_e        r_state;
  state_e        w_next;
  logic [BW-1:0] r_acc;
  logic [BW-1:0] r_result;
  logic [XW-1:0] r_idx;
  logic [IW-1:0] r_iters;

  logic [BW-1:0] w_mask;
  logic [BW-1:0] w_probe;
  logic          w_active;
  logic          w_sample;
  logic          w_early;
  logic          w_last;

  // Trial operand: accumulated bits plus the bit currently under test.
  assign w_mask   = BW'(bit_mask(32'(r_idx)));
  assign w_probe  = r_acc | w_mask;
  assign w_active = (r_state == S_PROBE) || (r_state == S_WAIT);
  // The comparator answer is taken in PROBE for a combinational comparator, in WAIT otherwise.
  assign w_sample = (CMP_LAT == 0) ? (r_state == S_PROBE) : (r_state == S_WAIT);
  // An eq without lte is an inconsistent comparator; it must not end the search.
  assign w_early  = (EARLY_EXIT != 0) && i_cmp_eq && i_cmp_lte;
  assign w_last   = (r_idx == '0);

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_next        = r_state;
    o_req_ready   = 1'b0;
    o_probe_valid = 1'b0;
    o_resp_valid  = 1'b0;
    o_probe       = '0;
    unique case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = S_PROBE;
      end
      S_PROBE: begin
        o_probe_valid = 1'b1;
        o_probe       = w_probe;
        if (i_abort)                w_next = S_IDLE;
        else if (CMP_LAT != 0)      w_next = S_WAIT;
        else if (w_early || w_last) w_next = S_DONE;
      end
      S_WAIT: begin
        o_probe = w_probe;
        if (i_abort)                w_next = S_IDLE;
        else if (w_early || w_last) w_next = S_DONE;
        else                        w_next = S_PROBE;
      end
      S_DONE: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Search datapath: accumulator, bit index, probe count and final result.
  always_ff @(posedge i_clk) begin
    // NOTE: result and iters are reset as well because they are visible outputs that must read 0 after reset.
    if (i_rst) begin
      r_acc    <= '0;
      r_idx    <= LAST_IDX;
      r_iters  <= '0;
      r_result <= '0;
    end else if (r_state == S_IDLE && i_req_valid) begin
      r_acc   <= '0;
      r_idx   <= LAST_IDX;
      r_iters <= '0;
    end else if (w_sample && !i_abort) begin
      r_iters <= r_iters + 1'b1;
      if (i_cmp_lte) r_acc <= w_probe;
      if (w_early) begin
        r_result <= w_probe;
      end else if (w_last) begin
        r_result <= i_cmp_lte ? w_probe : r_acc;
      end else begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

  assign o_result = r_result;
  assign o_iters  = r_iters;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: three instances (CMP_LAT=0/EARLY_EXIT=0, CMP_LAT=0/EARLY_EXIT=1,
// CMP_LAT=1/EARLY_EXIT=0), each answered by a behavioural comparator against a threshold.
module tb_sar_search;

  localparam int BW = 8;
  localparam int IW = 4;
  localparam int NI = 3;
  localparam int MAX_CYC = 100;

  typedef struct {
    logic [BW-1:0] result;
    int            iters;
    int            lat;
  } sb_item_t;

  sb_item_t      sb[$];
  logic [BW-1:0] exp_probes[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid   [NI];
  logic          req_ready   [NI];
  logic          abort_in    [NI];
  logic          probe_valid [NI];
  logic [BW-1:0] probe       [NI];
  logic          resp_valid  [NI];
  logic          resp_ready  [NI];
  logic [BW-1:0] result      [NI];
  logic [IW-1:0] iters       [NI];
  logic [BW-1:0] thr         [NI];
  logic          force_eq    [NI];
  logic [BW-1:0] last_result [NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic c_lte;
    logic c_eq;
    if (g == 2) begin : g_reg_cmp
      always_ff @(posedge clk) begin
        c_lte <= (probe[g] <= thr[g]);
        c_eq  <= (probe[g] == thr[g]) | force_eq[g];
      end
    end else begin : g_comb_cmp
      assign c_lte = (probe[g] <= thr[g]);
      assign c_eq  = (probe[g] == thr[g]) | force_eq[g];
    end

    sar_search #(
      .BW        (BW),
      .CMP_LAT   ((g == 2) ? 1 : 0),
      .EARLY_EXIT((g == 1) ? 1 : 0)
    ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid[g]),
      .o_req_ready  (req_ready[g]),
      .i_abort      (abort_in[g]),
      .o_probe_valid(probe_valid[g]),
      .o_probe      (probe[g]),
      .i_cmp_lte    (c_lte),
      .i_cmp_eq     (c_eq),
      .o_resp_valid (resp_valid[g]),
      .i_resp_ready (resp_ready[g]),
      .o_result     (result[g]),
      .o_iters      (iters[g])
    );
  end

  function automatic int lat_of(input int n);
    return (n == 2) ? 1 : 0;
  endfunction

  // Reference probe sequence for threshold t, derived from the MSB-first search definition.
  task automatic build_probes(input logic [BW-1:0] t, input bit ee);
    logic [BW-1:0] acc;
    logic [BW-1:0] p;
    exp_probes.delete();
    acc = '0;
    for (int i = BW - 1; i >= 0; i--) begin
      p = acc | (8'h01 << i);
      exp_probes.push_back(p);
      if (p <= t) acc = p;
      if (ee && p == t) break;
    end
  endtask

  task automatic accept(input int n, input string name);
    n_tests++;
    if (req_ready[n] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: req_ready=%b required 1", name, req_ready[n]);
    end
    req_valid[n] = 1'b1;
    @(negedge clk);
    req_valid[n] = 1'b0;
  endtask

  // Issue one request, check every probe against exp_probes, then the scoreboarded response.
  task automatic run_search(input int n, input logic [BW-1:0] t, input string name);
    sb_item_t      e;
    int            lat;
    logic [BW-1:0] prev;
    logic [BW-1:0] ep;
    thr[n]   = t;
    e.result = t;
    e.iters  = exp_probes.size();
    e.lat    = exp_probes.size() * (1 + lat_of(n));
    sb.push_back(e);
    accept(n, name);
    lat  = 0;
    prev = probe[n];
    while (resp_valid[n] !== 1'b1 && lat < MAX_CYC) begin
      n_tests++;
      if (probe_valid[n] === 1'b1) begin
        if (exp_probes.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_probe: probe=0x%02h required none", name, probe[n]);
        end else begin
          ep = exp_probes.pop_front();
          if (probe[n] !== ep) begin
            n_fail++;
            $display("FAIL %s probe: got 0x%02h required 0x%02h", name, probe[n], ep);
          end
        end
      end else if (probe[n] !== prev) begin
        n_fail++;
        $display("FAIL %s probe_hold: got 0x%02h required 0x%02h", name, probe[n], prev);
      end
      prev = probe[n];
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    n_tests++;
    if (lat >= MAX_CYC) begin
      n_fail++;
      $display("FAIL %s timeout: no resp_valid within %0d cycles", name, MAX_CYC);
    end else begin
      if (result[n] !== e.result) begin
        n_fail++;
        $display("FAIL %s result: got 0x%02h required 0x%02h", name, result[n], e.result);
      end
      n_tests++;
      if (iters[n] !== IW'(e.iters)) begin
        n_fail++;
        $display("FAIL %s iters: got %0d required %0d", name, iters[n], e.iters);
      end
      n_tests++;
      if (lat != e.lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
      end
      n_tests++;
      if (exp_probes.size() != 0) begin
        n_fail++;
        $display("FAIL %s probe_count: %0d probes missing", name, exp_probes.size());
      end
    end
    last_result[n] = e.result;
    if (resp_ready[n] === 1'b1) begin
      @(negedge clk);
      n_tests++;
      if (resp_valid[n] !== 1'b0 || req_ready[n] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s release: resp_valid=%b req_ready=%b required 0/1",
                 name, resp_valid[n], req_ready[n]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int n = 0; n < NI; n++) begin
      req_valid[n]   = 1'b0;
      abort_in[n]    = 1'b0;
      resp_ready[n]  = 1'b1;
      force_eq[n]    = 1'b0;
      thr[n]         = '0;
      last_result[n] = '0;
    end
    repeat (3) @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      n_tests++;
      if (req_ready[n] !== 1'b1 || probe_valid[n] !== 1'b0 || resp_valid[n] !== 1'b0 ||
          probe[n] !== '0 || result[n] !== '0 || iters[n] !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: rdy=%b pv=%b rv=%b probe=0x%02h result=0x%02h iters=%0d required 1/0/0/0/0/0",
                 n, req_ready[n], probe_valid[n], resp_valid[n], probe[n], result[n], iters[n]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_probes = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    run_search(0, 8'hA5, "basic_a5");
  endtask

  task automatic test_boundaries();
    build_probes(8'h00, 1'b0);
    run_search(0, 8'h00, "bound_00");
    build_probes(8'hFF, 1'b0);
    run_search(0, 8'hFF, "bound_ff");
  endtask

  task automatic test_early_exit();
    build_probes(8'h80, 1'b1);
    run_search(1, 8'h80, "ee_80");
    build_probes(8'h5A, 1'b1);
    run_search(1, 8'h5A, "ee_5a");
    // eq asserted while lte is low must neither end the search nor change the result
    force_eq[1] = 1'b1;
    build_probes(8'h00, 1'b0);
    run_search(1, 8'h00, "ee_bad_eq");
    force_eq[1] = 1'b0;
  endtask

  task automatic test_cmp_lat1();
    build_probes(8'h3C, 1'b0);
    run_search(2, 8'h3C, "lat1_3c");
  endtask

  task automatic test_back_to_back();
    build_probes(8'h00, 1'b0);
    run_search(2, 8'h00, "b2b_00");
    build_probes(8'hFF, 1'b0);
    run_search(2, 8'hFF, "b2b_ff");
  endtask

  task automatic test_abort();
    thr[0] = 8'h5A;
    accept(0, "abort_mid");
    repeat (3) @(negedge clk);
    abort_in[0] = 1'b1;
    @(negedge clk);
    abort_in[0] = 1'b0;
    n_tests++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || probe_valid[0] !== 1'b0 ||
        iters[0] !== 4'd3 || result[0] !== last_result[0]) begin
      n_fail++;
      $display("FAIL abort_mid: rdy=%b rv=%b pv=%b iters=%0d result=0x%02h required 1/0/0/3/0x%02h",
               req_ready[0], resp_valid[0], probe_valid[0], iters[0], result[0], last_result[0]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (resp_valid[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_resp: resp_valid=%b required 0", resp_valid[0]);
      end
    end
    // abort coinciding with the final sample must still win
    accept(0, "abort_last");
    repeat (7) @(negedge clk);
    abort_in[0] = 1'b1;
    @(negedge clk);
    abort_in[0] = 1'b0;
    n_tests++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || iters[0] !== 4'd7 ||
        result[0] !== last_result[0]) begin
      n_fail++;
      $display("FAIL abort_last: rdy=%b rv=%b iters=%0d result=0x%02h required 1/0/7/0x%02h",
               req_ready[0], resp_valid[0], iters[0], result[0], last_result[0]);
    end
    build_probes(8'h11, 1'b0);
    run_search(0, 8'h11, "after_abort_11");
  endtask

  task automatic test_back_pressure();
    resp_ready[0] = 1'b0;
    build_probes(8'hC3, 1'b0);
    run_search(0, 8'hC3, "bp_c3");
    for (int k = 0; k < 5; k++) begin
      req_valid[0] = 1'b1;
      abort_in[0]  = (k == 2);
      n_tests++;
      if (resp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0 || result[0] !== 8'hC3 ||
          iters[0] !== 4'd8) begin
        n_fail++;
        $display("FAIL bp_hold: rv=%b rdy=%b result=0x%02h iters=%0d required 1/0/0xc3/8",
                 resp_valid[0], req_ready[0], result[0], iters[0]);
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    abort_in[0]  = 1'b0;
    n_tests++;
    if (resp_valid[0] !== 1'b1 || result[0] !== 8'hC3) begin
      n_fail++;
      $display("FAIL bp_still_done: rv=%b result=0x%02h required 1/0xc3", resp_valid[0], result[0]);
    end
    resp_ready[0] = 1'b1;
    @(negedge clk);
    n_tests++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || probe_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: rv=%b rdy=%b pv=%b required 0/1/0",
               resp_valid[0], req_ready[0], probe_valid[0]);
    end
    @(negedge clk);
    n_tests++;
    if (probe_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_not_queued: probe_valid=%b required 0", probe_valid[0]);
    end
  endtask

  task automatic test_reset_mid_search();
    thr[0] = 8'h77;
    accept(0, "rst_mid");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready[0] !== 1'b1 || probe_valid[0] !== 1'b0 || resp_valid[0] !== 1'b0 ||
        probe[0] !== '0 || result[0] !== '0 || iters[0] !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: rdy=%b pv=%b rv=%b probe=0x%02h result=0x%02h iters=%0d required 1/0/0/0/0/0",
               req_ready[0], probe_valid[0], resp_valid[0], probe[0], result[0], iters[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    build_probes(8'h77, 1'b0);
    run_search(0, 8'h77, "after_rst_77");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_early_exit();
    test_cmp_lat1();
    test_back_to_back();
    test_abort();
    test_back_pressure();
    test_reset_mid_search();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
